// File: rtl/counter.sv
// counter: anode-scan sequencer for a 4-digit common-anode 7-segment display.
// Ports:
//   AN_EN     - active-low anode enables, bit 3 = leftmost digit
//   clk       - system clock, rising edge
//   reset     - asynchronous active-low reset
//   digit_idx - index of the enabled digit, valid while blank=0
//   blank     - high during guard phases and during reset
module counter #(
  parameter int DIV = 1,
  parameter int PW  = 16
) (
  output logic [3:0] AN_EN,
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] digit_idx,
  output logic       blank
);
  logic [PW-1:0] pre;
  logic [3:0]    cnt;
  logic [3:0]    nxt;
  logic [1:0]    d;
  logic          tick;
  logic          guard;
  assign tick  = pre == PW'(DIV - 1);
  assign nxt   = cnt + 4'd1;
  // Outputs decode the phase being entered so they align with cnt.
  assign guard = nxt[1:0] == 2'b00;
  // 3 - n[3:2] for a 2-bit value is its bitwise complement.
  assign d     = ~nxt[3:2];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre       <= '0;
      cnt       <= '0;
      AN_EN     <= 4'b1111;
      digit_idx <= '0;
      blank     <= 1'b1;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        cnt   <= nxt;
        AN_EN <= guard ? 4'b1111 : ~(4'b0001 << d);
        blank <= guard;
        if (!guard) digit_idx <= d;
      end
    end
  end
endmodule

// File: tb/tb_counter.sv
// tb_counter: randomized self-checking bench for counter at DIV=1 and DIV=4.
module tb_counter;
  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst1 = 1'b0;
  logic       rst4 = 1'b0;
  logic [3:0] an1, an4;
  logic [1:0] di1, di4;
  logic       bl1, bl4;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         e1 = 0;
  int         e4 = 0;
  logic [1:0] ld1 = 2'd0;
  logic [1:0] ld4 = 2'd0;
  logic [3:0] seq [16] = '{4'b1111, 4'b0111, 4'b0111, 4'b0111,
                           4'b1111, 4'b1011, 4'b1011, 4'b1011,
                           4'b1111, 4'b1101, 4'b1101, 4'b1101,
                           4'b1111, 4'b1110, 4'b1110, 4'b1110};

  always #5 if (clk_en) clk = ~clk;

  counter #(.DIV(1)) u1 (.AN_EN(an1), .clk(clk), .reset(rst1), .digit_idx(di1), .blank(bl1));
  counter #(.DIV(4)) u4 (.AN_EN(an4), .clk(clk), .reset(rst4), .digit_idx(di4), .blank(bl4));

  // Reference: count released edges, phase = ticks mod 16, digit remembered across guards.
  always @(posedge clk) begin
    int ph;
    if (rst1) begin
      e1++;
      ph = e1 % 16;
      if (ph % 4 != 0) ld1 = 2'(3 - ph / 4);
    end
    if (rst4) begin
      e4++;
      ph = (e4 / 4) % 16;
      if (ph % 4 != 0) ld4 = 2'(3 - ph / 4);
    end
  end

  task automatic restart1();
    @(negedge clk);
    rst1 = 1'b0; e1 = 0; ld1 = 2'd0;
    #2 rst1 = 1'b1;
  endtask

  task automatic restart4();
    @(negedge clk);
    rst4 = 1'b0; e4 = 0; ld4 = 2'd0;
    #2 rst4 = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (an1 !== 4'b1111 || bl1 !== 1'b1 || di1 !== 2'd0) begin
      n_bad++; $display("FAIL reset_div1: got an=%b bl=%b di=%0d want an=1111 bl=1 di=0", an1, bl1, di1);
    end
    n_cmp++;
    if (an4 !== 4'b1111 || bl4 !== 1'b1 || di4 !== 2'd0) begin
      n_bad++; $display("FAIL reset_div4: got an=%b bl=%b di=%0d want an=1111 bl=1 di=0", an4, bl4, di4);
    end
    restart1();
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (an1 !== 4'b1011) begin
      n_bad++; $display("FAIL pre_reset_cnt6: got an=%b want 1011", an1);
    end
    #1 rst1 = 1'b0; e1 = 0; ld1 = 2'd0;
    #1;
    n_cmp++;
    if (an1 !== 4'b1111 || bl1 !== 1'b1 || di1 !== 2'd0) begin
      n_bad++; $display("FAIL async_reset: got an=%b bl=%b di=%0d want an=1111 bl=1 di=0", an1, bl1, di1);
    end
    @(negedge clk);
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (an1 !== 4'b0111 || bl1 !== 1'b0 || di1 !== 2'd3) begin
      n_bad++; $display("FAIL release_edge1: got an=%b bl=%b di=%0d want an=0111 bl=0 di=3", an1, bl1, di1);
    end
  endtask

  task automatic test_full_scan();
    restart1();
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (an1 !== seq[e1 % 16] || bl1 !== (seq[e1 % 16] == 4'b1111) || di1 !== ld1) begin
        n_bad++;
        $display("FAIL scan_edge%0d: got an=%b bl=%b di=%0d want an=%b bl=%b di=%0d",
                 i, an1, bl1, di1, seq[e1 % 16], seq[e1 % 16] == 4'b1111, ld1);
      end
    end
    n_cmp++;
    if (an1 !== 4'b0111 || di1 !== 2'd3 || bl1 !== 1'b0) begin
      n_bad++; $display("FAIL wrap_edge17: got an=%b bl=%b di=%0d want an=0111 bl=0 di=3", an1, bl1, di1);
    end
  endtask

  task automatic test_prescale();
    restart4();
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (an4 !== seq[(e4 / 4) % 16] || bl4 !== (seq[(e4 / 4) % 16] == 4'b1111) || di4 !== ld4) begin
        n_bad++;
        $display("FAIL prescale_edge%0d: got an=%b bl=%b di=%0d want an=%b di=%0d",
                 i, an4, bl4, di4, seq[(e4 / 4) % 16], ld4);
      end
      if (i == 3 || i == 4) begin
        n_cmp++;
        if (an4 !== (i == 3 ? 4'b1111 : 4'b0111)) begin
          n_bad++; $display("FAIL prescale_first_tick edge%0d: got an=%b", i, an4);
        end
      end
    end
  endtask

  task automatic test_clock_stop();
    logic [3:0] a1, a4;
    logic [1:0] d1, d4;
    logic       b1, b4;
    @(negedge clk);
    clk_en = 1'b0;
    a1 = an1; a4 = an4; d1 = di1; d4 = di4; b1 = bl1; b4 = bl4;
    for (int t = 0; t < 8; t++) begin
      #10;
      n_cmp++;
      if ({an1, di1, bl1, an4, di4, bl4} !== {a1, d1, b1, a4, d4, b4}) begin
        n_bad++;
        $display("FAIL clock_stop t=%0d: got %b/%0d/%b %b/%0d/%b want %b/%0d/%b %b/%0d/%b",
                 t, an1, di1, bl1, an4, di4, bl4, a1, d1, b1, a4, d4, b4);
      end
    end
    clk_en = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        @(negedge clk);
        #($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 0) begin
          rst1 = 1'b0; e1 = 0; ld1 = 2'd0;
        end else begin
          rst4 = 1'b0; e4 = 0; ld4 = 2'd0;
        end
        #1;
        n_cmp++;
        if ((!rst1 && (an1 !== 4'b1111 || bl1 !== 1'b1 || di1 !== 2'd0)) ||
            (!rst4 && (an4 !== 4'b1111 || bl4 !== 1'b1 || di4 !== 2'd0))) begin
          n_bad++; $display("FAIL random_reset it=%0d: got an1=%b an4=%b bl1=%b bl4=%b", i, an1, an4, bl1, bl4);
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(negedge clk);
        rst1 = 1'b1; rst4 = 1'b1;
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (an1 !== seq[e1 % 16] || di1 !== ld1 || an4 !== seq[(e4 / 4) % 16] || di4 !== ld4) begin
        n_bad++;
        $display("FAIL random_model it=%0d: got an1=%b di1=%0d an4=%b di4=%0d want an1=%b di1=%0d an4=%b di4=%0d",
                 i, an1, di1, an4, di4, seq[e1 % 16], ld1, seq[(e4 / 4) % 16], ld4);
      end
      n_cmp++;
      if (!(an1 inside {4'b1111, 4'b0111, 4'b1011, 4'b1101, 4'b1110}) || bl1 !== (an1 == 4'b1111) ||
          (!bl1 && an1[di1] !== 1'b0) ||
          !(an4 inside {4'b1111, 4'b0111, 4'b1011, 4'b1101, 4'b1110}) || bl4 !== (an4 == 4'b1111) ||
          (!bl4 && an4[di4] !== 1'b0)) begin
        n_bad++;
        $display("FAIL invariant it=%0d: got an1=%b bl1=%b di1=%0d an4=%b bl4=%b di4=%0d",
                 i, an1, bl1, di1, an4, bl4, di4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_prescale();
    test_clock_stop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/counter.md
Name: counter

Overview:
- Anode-scan sequencer for a 4-digit, common-anode 7-segment display.
- A prescaled 4-bit phase counter steps through 16 phases: 4 per digit, the first of each group a blanking guard.
- The counter drives a registered, active-low 4-bit anode-enable bus.
- Sits between the system clock and the display mux; the segment-data path uses the anode bus to select the digit value.

Parameters:
- DIV, default 1: clock cycles per phase step. Legal range 1..2^16. DIV=1 advances one phase every clock.
- PW, default 16: prescaler width. Requirement: DIV ≤ 2^PW.

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-low reset. 0 resets; release is synchronised by design convention.
- AN_EN  output  4  anode enables, active-low; bit k = digit k (bit 3 = leftmost). At most one bit is 0 at any time.
- digit_idx  output  2  index of the digit currently enabled; valid only when blank=0.
- blank  output  1  1 during guard phases and during reset.
- Declaration/positional order: AN_EN, clk, reset, digit_idx, blank.
  - Existing instances connect only (AN_EN, clk) positionally.
  - Unconnected reset must not be a problem in simulation; tie-off is the integrator's responsibility.

Behaviour:
- State: prescaler pre[PW-1:0], phase counter cnt[3:0], registered outputs AN_EN, digit_idx, blank.
- Reset (reset=0, asynchronous, immediate, including mid-operation):
  - pre=0, cnt=0.
  - AN_EN=4'b1111, digit_idx=0, blank=1.
- Tick: tick=1 when pre==DIV-1.
  - Each rising clk: if tick, pre←0; else pre←pre+1.
  - DIV=1 ⇒ tick every cycle.
- On tick: cnt←cnt+1, wrapping 15→0. No change to cnt otherwise.
- Decode of a phase value n, registered at the same edge cnt takes value n (outputs align with cnt; no extra latency):
  - Guard: n[1:0]==2'b00 ⇒ AN_EN=1111, blank=1, digit_idx holds its previous value.
  - Otherwise: d = 3 − n[3:2]; AN_EN has bit d =0 and all others 1; digit_idx=d; blank=0.
- Resulting sequence (cnt 0..15):
  - cnt 0: AN_EN 1111
  - cnt 1–3: 0111
  - cnt 4: 1111
  - cnt 5–7: 1011
  - cnt 8: 1111
  - cnt 9–11: 1101
  - cnt 12: 1111
  - cnt 13–15: 1110
  - then repeats.
- Guarantees:
  - One-hot-low or all-high only; never two digits enabled simultaneously (ghosting protection).
  - Outputs change only on the clk rising edge or on reset assertion.
  - Reset release: first tick occurs DIV rising edges after release; the first edge with reset=1 counts as edge 1.
- Non-tick edges: all outputs hold.

Test Plan:
- Reset assert mid-sequence with DIV=1: drive reset=0 while cnt=6 → AN_EN=1111, blank=1 immediately, before any clk edge. Release → edge 1 gives AN_EN=0111.
- Full scan with DIV=1: 16 rising edges after release → AN_EN sequence 0111,0111,0111,1111,1011,1011,1011,1111,1101,1101,1101,1111,1110,1110,1110,1111. Edge 16 is wrap to cnt=0.
- Wrap continuity with DIV=1: edge 17 → AN_EN=0111, digit_idx=3, blank=0.
- Prescale with DIV=4: AN_EN stays 1111 for edges 1–3, becomes 0111 at edge 4, then steps every 4 edges.
- Clock stop: hold clk low 80 ns with reset=1 → no output change.
- Invariant check every cycle: AN_EN ∈ {1111, 0111, 1011, 1101, 1110}. blank==1 iff AN_EN==1111. When blank=0, AN_EN[digit_idx]==0.
